// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the multi-channel fan controller: register map
// offsets, STAT bit positions and the Wishbone address decode helpers.
package fan_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF_DUTY   = 2'd0,
      OFF_TACH   = 2'd1,
      OFF_THRESH = 2'd2,
      OFF_STAT   = 2'd3
   } regOff_e;

   localparam logic [5:0] ADR_SUMMARY = 6'h3F;

   localparam int STAT_STALL_BIT = 0;
   localparam int STAT_MASK_BIT  = 1;

   // Each channel owns four consecutive words starting at 4*channel.
   function automatic logic [3:0] adrChan(input logic [5:0] adr);
      return adr[5:2];
   endfunction

   function automatic regOff_e adrOff(input logic [5:0] adr);
      return regOff_e'(adr[1:0]);
   endfunction

endpackage

// File: rtl/fan_tach.sv
// One tachometer channel: input synchroniser, falling-edge counter with
// saturation, per-window latch and sticky stall flag.
module fan_tach
   import fan_ctrl_pkg::*;
#(
   parameter int CNT_W = 27
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             fan_i,
   input  logic             winEnd_i,
   input  logic [CNT_W-1:0] thresh_i,
   input  logic             clrStall_i,
   output logic [CNT_W-1:0] tach_o,
   output logic             stall_o
);

   logic [2:0]       sync_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] tach_q, tach_d;
   logic             stall_q, stall_d;
   logic             fallEdge;

   assign fallEdge = sync_q[2] & ~sync_q[1];

   // An edge seen in the window-end cycle belongs to the next window, and a
   // stall set in that cycle overrides a simultaneous software clear.
   always_comb begin
      count_d = count_q;
      tach_d  = tach_q;
      stall_d = stall_q;
      if (clrStall_i) begin
         stall_d = 1'b0;
      end
      if (winEnd_i) begin
         tach_d  = count_q;
         count_d = fallEdge ? CNT_W'(1) : '0;
         if ((thresh_i != '0) && (count_q < thresh_i)) begin
            stall_d = 1'b1;
         end
      end else if (fallEdge && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         sync_q  <= '0;
         count_q <= '0;
         tach_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], fan_i};
         count_q <= count_d;
         tach_q  <= tach_d;
         stall_q <= stall_d;
      end
   end

   assign tach_o  = tach_q;
   assign stall_o = stall_q;

endmodule

// File: rtl/fan_ctrl.sv
// Wishbone fan controller top: register decode, shared PWM and window
// counters, per-channel tach instances, registered read mux and interrupt.
module fan_ctrl
   import fan_ctrl_pkg::*;
#(
   parameter int NCH      = 2,
   parameter int PWM_W    = 10,
   parameter int CNT_W    = 27,
   parameter int TACH_WIN = 49_999_999
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             STB_I,
   input  logic             WE_I,
   input  logic [5:0]       ADR_I,
   input  logic [31:0]      DAT_I,
   output logic             ACK_O,
   output logic [31:0]      DAT_O,
   output logic             ERR_O,
   output logic             RTY_O,
   input  logic [NCH-1:0]   FAN_IN,
   output logic [NCH-1:0]   PWM_O,
   output logic             IRQ_O
);

   localparam int WIN_W = (TACH_WIN > 0) ? $clog2(TACH_WIN + 1) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TACH_WIN);

   logic             ack_q;
   logic [31:0]      dat_q;
   logic [31:0]      readData;
   logic             access, wrAccess;
   logic [3:0]       chan;
   regOff_e          off;
   logic [NCH-1:0]   chanSel;
   logic [NCH-1:0]   clrStall;

   logic [PWM_W-1:0] pwmCnt_q;
   logic [WIN_W-1:0] winCnt_q;
   logic             winEnd;

   logic [PWM_W-1:0] dutyShadow_q [NCH];
   logic [PWM_W-1:0] dutyActive_q [NCH];
   logic [CNT_W-1:0] thresh_q     [NCH];
   logic [CNT_W-1:0] tach         [NCH];
   logic [NCH-1:0]   mask_q;
   logic [NCH-1:0]   stall;

   assign access   = STB_I & ~ack_q;
   assign wrAccess = access & WE_I;
   assign chan     = adrChan(ADR_I);
   assign off      = adrOff(ADR_I);
   assign winEnd   = (winCnt_q == WIN_LAST);

   always_comb begin
      chanSel  = '0;
      clrStall = '0;
      for (int c = 0; c < NCH; c++) begin
         chanSel[c]  = (chan == 4'(c));
         clrStall[c] = wrAccess & chanSel[c] & (off == OFF_STAT) & DAT_I[STAT_STALL_BIT];
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         for (int c = 0; c < NCH; c++) begin
            dutyShadow_q[c] <= '0;
            thresh_q[c]     <= '0;
         end
         mask_q <= '1;
      end else if (wrAccess) begin
         for (int c = 0; c < NCH; c++) begin
            if (chanSel[c]) begin
               case (off)
                  OFF_DUTY:   dutyShadow_q[c] <= DAT_I[PWM_W-1:0];
                  OFF_THRESH: thresh_q[c]     <= DAT_I[CNT_W-1:0];
                  OFF_STAT:   mask_q[c]       <= DAT_I[STAT_MASK_BIT];
                  default:    ;
               endcase
            end
         end
      end
   end

   // Active duty only changes at the wrap so every period is whole.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         pwmCnt_q <= '0;
         winCnt_q <= '0;
         for (int c = 0; c < NCH; c++) begin
            dutyActive_q[c] <= '0;
         end
      end else begin
         pwmCnt_q <= pwmCnt_q + PWM_W'(1);
         winCnt_q <= winEnd ? '0 : winCnt_q + WIN_W'(1);
         if (pwmCnt_q == '1) begin
            for (int c = 0; c < NCH; c++) begin
               dutyActive_q[c] <= dutyShadow_q[c];
            end
         end
      end
   end

   always_comb begin
      PWM_O = '0;
      for (int c = 0; c < NCH; c++) begin
         PWM_O[c] = (pwmCnt_q < dutyActive_q[c]);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : gTach
      fan_tach #(
         .CNT_W (CNT_W)
      ) uTach (
         .CLK_I      (CLK_I),
         .RST_I      (RST_I),
         .fan_i      (FAN_IN[g]),
         .winEnd_i   (winEnd),
         .thresh_i   (thresh_q[g]),
         .clrStall_i (clrStall[g]),
         .tach_o     (tach[g]),
         .stall_o    (stall[g])
      );
   end

   always_comb begin
      readData = '0;
      if (ADR_I == ADR_SUMMARY) begin
         readData = 32'(stall);
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (chanSel[c]) begin
               case (off)
                  OFF_DUTY:   readData = 32'(dutyShadow_q[c]);
                  OFF_TACH:   readData = 32'(tach[c]);
                  OFF_THRESH: readData = 32'(thresh_q[c]);
                  default: begin
                     readData[STAT_STALL_BIT] = stall[c];
                     readData[STAT_MASK_BIT]  = mask_q[c];
                  end
               endcase
            end
         end
      end
   end

   // Read data is only presented in the acknowledge cycle.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= access;
         dat_q <= (access & ~WE_I) ? readData : '0;
      end
   end

   assign ACK_O = ack_q;
   assign DAT_O = dat_q;
   assign ERR_O = 1'b0;
   assign RTY_O = 1'b0;
   assign IRQ_O = |(stall & ~mask_q);

endmodule

// File: tb/tb_fan_ctrl.sv
// Bench for fan_ctrl: register-map vector table, directed window/stall/bus
// sequences and random PWM/tach traffic compared with a cycle-indexed model.
module tb_fan_ctrl;
   import fan_ctrl_pkg::*;

   localparam int NCH      = 2;
   localparam int PWM_W    = 4;
   localparam int CNT_W    = 8;
   localparam int TACH_WIN = 599;
   localparam int WIN_LEN  = TACH_WIN + 1;
   localparam int PERIOD   = 1 << PWM_W;
   localparam int NWIN     = 16;

   logic           CLK_I = 1'b0;
   logic           RST_I = 1'b1;
   logic           STB_I = 1'b0;
   logic           WE_I  = 1'b0;
   logic [5:0]     ADR_I = '0;
   logic [31:0]    DAT_I = '0;
   logic           ACK_O, ERR_O, RTY_O, IRQ_O;
   logic [31:0]    DAT_O;
   logic [NCH-1:0] FAN_IN = '1;
   logic [NCH-1:0] PWM_O;

   always #5 CLK_I = ~CLK_I;

   fan_ctrl #(
      .NCH(NCH), .PWM_W(PWM_W), .CNT_W(CNT_W), .TACH_WIN(TACH_WIN)
   ) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I),
      .ADR_I(ADR_I), .DAT_I(DAT_I), .ACK_O(ACK_O), .DAT_O(DAT_O),
      .ERR_O(ERR_O), .RTY_O(RTY_O), .FAN_IN(FAN_IN), .PWM_O(PWM_O),
      .IRQ_O(IRQ_O)
   );

   int cyc;
   always @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   int assertCount = 0;
   int failCount   = 0;
   bit finished    = 0;

   int fanMode     [NCH];
   int edgesPerWin [NCH];
   bit extraOdd    [NCH];
   int edgeCnt     [NCH][NWIN];

   typedef struct {int ch; int cyc; int val;} dutyEv_t;
   dutyEv_t dutyLog[$];
   bit pwmCheckEn = 0;

   typedef struct {bit we; logic [5:0] adr; logic [31:0] wdat; logic [31:0] exp;} vec_t;
   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // A falling input edge is counted two cycles later; the window it lands
   // in runs from one cycle before each window start.
   function automatic void recordEdge(input int c, input int detCyc);
      int w;
      w = (detCyc + 1) / WIN_LEN;
      if (w < NWIN) edgeCnt[c][w]++;
   endfunction

   function automatic int sat(input int n);
      return (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
   endfunction

   function automatic int expTach(input int c, input int accCyc);
      int k;
      k = accCyc / WIN_LEN;
      return (k == 0) ? 0 : sat(edgeCnt[c][k-1]);
   endfunction

   function automatic bit stallFrom(input int c, input int w, input int th);
      return (th != 0) && (sat(edgeCnt[c][w]) < th);
   endfunction

   function automatic int expDuty(input int c, input int n);
      int k, d;
      k = n / PERIOD;
      d = 0;
      if (k == 0) return 0;
      foreach (dutyLog[i]) begin
         if (dutyLog[i].ch == c && dutyLog[i].cyc <= PERIOD * k - 2) d = dutyLog[i].val;
      end
      return d;
   endfunction

   always begin
      logic nxt;
      int   off;
      @(posedge CLK_I);
      #1;
      if (!RST_I) begin
         for (int c = 0; c < NCH; c++) begin
            off = cyc % WIN_LEN;
            case (fanMode[c])
               1: nxt = FAN_IN[c] ? ($urandom_range(0, 15) != 0) : 1'b1;
               2: nxt = ~FAN_IN[c];
               3: nxt = !(((off % 50 == 10) && (off / 50 < edgesPerWin[c])) ||
                          (extraOdd[c] && off == 597 && ((cyc / WIN_LEN) % 2 == 1)));
               default: nxt = 1'b1;
            endcase
            if (FAN_IN[c] && !nxt) recordEdge(c, cyc + 2);
            FAN_IN[c] = nxt;
         end
      end
   end

   always @(negedge CLK_I) begin
      if (pwmCheckEn) begin
         for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("pwm%0d@%0d", c, cyc), 32'(PWM_O[c]),
                        32'((cyc % PERIOD) < expDuty(c, cyc)));
         end
      end
   end

   task automatic applyStimulus(input bit we, input logic [5:0] adr, input logic [31:0] wd,
                                output logic [31:0] rd, output int accCyc);
      accCyc = cyc;
      STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
      @(posedge CLK_I); #1;
      checkOutput("ack", 32'(ACK_O), 32'd1);
      rd = DAT_O;
      STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
      @(posedge CLK_I); #1;
      checkOutput("ackDrop", 32'(ACK_O), 32'd0);
   endtask

   task automatic busWrite(input logic [5:0] adr, input logic [31:0] wd);
      logic [31:0] rd;
      int ac;
      applyStimulus(1'b1, adr, wd, rd, ac);
      if (int'(adr[5:2]) < NCH && adr[1:0] == 2'd0)
         dutyLog.push_back('{int'(adr[5:2]), ac, int'(wd[PWM_W-1:0])});
   endtask

   task automatic readCheck(input string name, input logic [5:0] adr, input logic [31:0] exp);
      logic [31:0] rd;
      int ac;
      applyStimulus(1'b0, adr, '0, rd, ac);
      checkOutput(name, rd, exp);
   endtask

   task automatic waitCycle(input int n);
      int guard;
      guard = 0;
      while (cyc < n && guard < 50000) begin
         @(posedge CLK_I); #1;
         guard++;
      end
      if (cyc != n) begin
         failCount++;
         $display("[TB] FAIL waitCycle: at cycle %0d, required %0d", cyc, n);
      end
   endtask

   task automatic randomDutyWrites(input int count);
      int c;
      for (int i = 0; i < count; i++) begin
         waitCycle(cyc + $urandom_range(3, 40));
         c = $urandom_range(0, NCH - 1);
         busWrite(6'(c * 4), $urandom);
      end
   endtask

   initial begin
      logic [31:0] rd;
      int ac;

      fanMode[0] = 3; edgesPerWin[0] = 5;  extraOdd[0] = 1'b0;
      fanMode[1] = 3; edgesPerWin[1] = 10; extraOdd[1] = 1'b1;

      vecs.push_back('{1'b0, 6'h00, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h01, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h02, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h03, 32'h0, 32'h2});
      vecs.push_back('{1'b0, 6'h04, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h05, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h06, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h07, 32'h0, 32'h2});
      vecs.push_back('{1'b0, 6'h3F, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h08, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 6'h3E, 32'h0, 32'h0});
      vecs.push_back('{1'b1, 6'h00, 32'hFFFF_FFF5, 32'h5});
      vecs.push_back('{1'b1, 6'h04, 32'h0000_0003, 32'h3});
      vecs.push_back('{1'b1, 6'h06, 32'h0000_01FF, 32'hFF});
      vecs.push_back('{1'b1, 6'h06, 32'h0, 32'h0});
      vecs.push_back('{1'b1, 6'h02, 32'h8, 32'h8});
      vecs.push_back('{1'b1, 6'h03, 32'h0, 32'h0});
      vecs.push_back('{1'b1, 6'h07, 32'h3, 32'h2});
      vecs.push_back('{1'b1, 6'h05, 32'h55, 32'h0});
      vecs.push_back('{1'b1, 6'h08, 32'h7, 32'h0});
      vecs.push_back('{1'b1, 6'h3F, 32'hFF, 32'h0});
      vecs.push_back('{1'b1, 6'h03, 32'h1, 32'h0});

      repeat (3) @(posedge CLK_I);
      #1;
      checkOutput("rstAck", 32'(ACK_O), 32'd0);
      checkOutput("rstDat", DAT_O, 32'd0);
      checkOutput("rstPwm", 32'(PWM_O), 32'd0);
      checkOutput("rstIrq", 32'(IRQ_O), 32'd0);
      checkOutput("errRty", {30'b0, ERR_O, RTY_O}, 32'd0);
      RST_I = 1'b0;
      pwmCheckEn = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].we) busWrite(vecs[i].adr, vecs[i].wdat);
         readCheck($sformatf("vec%0d adr 0x%0h", i, vecs[i].adr), vecs[i].adr, vecs[i].exp);
      end
      checkOutput("irqMaskedOff", 32'(IRQ_O), 32'd0);

      // Duty change in the middle of a period, then random duty traffic.
      waitCycle(8 * PERIOD + 7);
      busWrite(6'h00, 32'd12);
      randomDutyWrites(8);

      waitCycle(WIN_LEN - 1);
      checkOutput("irqBeforeWinEnd", 32'(IRQ_O), 32'd0);
      waitCycle(WIN_LEN);
      checkOutput("irqAtStall", 32'(IRQ_O), 32'(stallFrom(0, 0, 8)));
      readCheck("stat0Stall", 6'h03, 32'(stallFrom(0, 0, 8)));
      readCheck("summaryW0", ADR_SUMMARY, {30'b0, stallFrom(1, 0, 0), stallFrom(0, 0, 8)});
      readCheck("tach0W0", 6'h01, 32'(expTach(0, cyc)));
      readCheck("tach1W0", 6'h05, 32'(expTach(1, cyc)));
      busWrite(6'h03, 32'h1);
      readCheck("stat0Cleared", 6'h03, 32'h0);
      checkOutput("irqCleared", 32'(IRQ_O), 32'd0);

      // Clear request in the very cycle the window closes.
      waitCycle(2 * WIN_LEN - 1);
      busWrite(6'h03, 32'h1);
      readCheck("stat0SetWins", 6'h03, 32'(stallFrom(0, 1, 8)));
      checkOutput("irqSetWins", 32'(IRQ_O), 32'(stallFrom(0, 1, 8)));
      readCheck("tach1W1", 6'h05, 32'(expTach(1, cyc)));
      busWrite(6'h06, 32'd11);
      busWrite(6'h03, 32'h3);
      readCheck("stat0Masked", 6'h03, 32'h2);
      checkOutput("irqMasked", 32'(IRQ_O), 32'd0);
      fanMode[0] = 2;

      waitCycle(3 * WIN_LEN + 1);
      readCheck("summaryW2", ADR_SUMMARY, {30'b0, stallFrom(1, 2, 11), stallFrom(0, 2, 8)});
      readCheck("tach0W2", 6'h01, 32'(expTach(0, cyc)));
      readCheck("tach1W2", 6'h05, 32'(expTach(1, cyc)));
      checkOutput("irqW2", 32'(IRQ_O), 32'd0);

      waitCycle(4 * WIN_LEN + 1);
      readCheck("summaryW3", ADR_SUMMARY,
                {30'b0, stallFrom(1, 2, 11) | stallFrom(1, 3, 11),
                 stallFrom(0, 2, 8) | stallFrom(0, 3, 8)});
      readCheck("tach0Sat", 6'h01, 32'(expTach(0, cyc)));
      readCheck("tach1W3", 6'h05, 32'(expTach(1, cyc)));
      fanMode[1] = 1;

      for (int k = 5; k <= 8; k++) begin
         randomDutyWrites(2);
         waitCycle(k * WIN_LEN + 1);
         readCheck($sformatf("tach0Rnd%0d", k), 6'h01, 32'(expTach(0, cyc)));
         readCheck($sformatf("tach1Rnd%0d", k), 6'h05, 32'(expTach(1, cyc)));
         checkOutput($sformatf("irqRnd%0d", k), 32'(IRQ_O), 32'd0);
      end

      // Held strobe: acknowledged every second cycle, data only with ACK.
      STB_I = 1'b1; WE_I = 1'b0; ADR_I = 6'h02;
      checkOutput("heldAck0", 32'(ACK_O), 32'd0);
      checkOutput("heldDat0", DAT_O, 32'd0);
      for (int i = 1; i <= 6; i++) begin
         @(posedge CLK_I); #1;
         checkOutput($sformatf("heldAck%0d", i), 32'(ACK_O), 32'(i % 2));
         checkOutput($sformatf("heldDat%0d", i), DAT_O, (i % 2 == 1) ? 32'd8 : 32'd0);
      end

      @(posedge CLK_I); #1;
      checkOutput("ackBeforeRst", 32'(ACK_O), 32'd1);
      pwmCheckEn = 1'b0;
      RST_I = 1'b1;
      #1;
      checkOutput("rstAbortAck", 32'(ACK_O), 32'd0);
      checkOutput("rstAbortDat", DAT_O, 32'd0);
      checkOutput("rstAbortPwm", 32'(PWM_O), 32'd0);
      checkOutput("rstAbortIrq", 32'(IRQ_O), 32'd0);
      STB_I = 1'b0;
      @(posedge CLK_I); #1;
      RST_I = 1'b0;
      @(posedge CLK_I); #1;
      checkOutput("postRstAck", 32'(ACK_O), 32'd0);

      finished = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #2_000_000;
      if (!finished) begin
         failCount++;
         $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
         $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
         $finish;
      end
   end

endmodule
